div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Iterative 32-bit divider for DIV/DIVU in the EX stage. Produces {remainder, quotient}
//  in hilo_i format (hi = remainder, lo = quotient), consumed by the HI/LO register in MEM.
//  Radix-2 restoring, one quotient bit per cycle; stalls the pipeline while busy.
// PARAMETERS
//  WIDTH     32   operand width; result is 2*WIDTH
//  CNT_W     5    iteration counter width, clog2(WIDTH)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  start_i      in   1      DIV/DIVU decoded in EX; request a division
//  signed_i     in   1      1 = DIV (two's complement), 0 = DIVU
//  a_i          in   32     dividend (rs)
//  b_i          in   32     divisor (rt)
//  flush_i      in   1      exception/eret flush; aborts the current operation
//  ready_i      in   1      downstream accepts the result this cycle
//  stall_o      out  1      hold IF/ID/EX: division is being computed
//  result_o     out  64     {remainder[31:0], quotient[31:0]}
//  valid_o      out  1      result_o valid; feeds hilo write enable
// BEHAVIOUR
//  Reset: state=IDLE; result_o=0; valid_o=0; counter=0. All outputs are 0 in the rst cycle.
//  FSM states (encoded in defines.vh): IDLE, BUSY, DONE.
//   IDLE: start_i & ~flush_i & b_i!=0 -> BUSY; latch |a|, |b|, neg_q = signed_i&(a[31]^b[31]),
//         neg_r = signed_i&a[31]; clear counter and partial remainder.
//         start_i & ~flush_i & b_i==0 -> DONE; result_o = {a_i, 32'hFFFF_FFFF} (raw a_i, no
//         sign fix).
//   BUSY: each cycle r' = {r[30:0], a_msb}; if r' >= |b| then subtract, q bit = 1.
//         After counter==31 (32 steps) -> DONE; apply sign fix: q = neg_q ? -q : q,
//         r = neg_r ? -r : r, all modulo 2^32.
//   DONE: valid_o=1, result_o held stable. ready_i -> IDLE; else stay (result and valid held).
//  stall_o = (IDLE & start_i & ~flush_i & b_i!=0) | BUSY. Combinational; never 1 in DONE.
//  Latency: start accepted at cycle 0; BUSY cycles 1..32; valid_o=1 from cycle 33.
//   Divide-by-zero: valid_o=1 at cycle 1, no stall.
//  flush_i: highest priority in every state; next state IDLE, valid_o=0 next cycle,
//   result_o keeps its last value. flush_i with start_i in IDLE: request dropped.
//  rst mid-operation: identical to flush plus result_o cleared.
//  start_i while BUSY/DONE: ignored (EX is held by stall/ready; no queueing).
//  DONE & ready_i & start_i: returns to IDLE; new request taken the following cycle.
//  Overflow: signed 0x8000_0000 / 0xFFFF_FFFF -> q=0x8000_0000, r=0 (natural wrap, no trap).
//  Arithmetic: partial remainder kept 33 bits wide for the compare/subtract; the magnitude
//   of 0x8000_0000 is represented as unsigned 0x8000_0000.
// STRUCTURE
//  defines.vh: DIV_IDLE/DIV_BUSY/DIV_DONE state codes, DIV_ITER=32; existing EXE_DIV/EXE_DIVU
//   funct codes used by the decoder that drives start_i/signed_i.
//  Single module; no sub-module. Sign-fix and magnitude logic stay inline (shared negator).
// TESTING
//  1 DIVU a=100 b=7 -> stall_o cycles 0..32, valid_o at 33, result_o=64'h00000002_0000000E.
//  2 DIV a=-7 (FFFFFFF9) b=2 -> result_o=64'hFFFFFFFF_FFFFFFFD (r=-1, q=-3).
//  3 DIV a=80000000 b=FFFFFFFF -> result_o=64'h00000000_80000000; DIVU FFFFFFFF/1 -> q=FFFFFFFF,r=0.
//  4 DIVU a=5 b=0 -> no stall, valid_o at cycle 1, result_o=64'h00000005_FFFFFFFF.
//  5 start then flush_i at cycle 10 -> stall_o=0 from 11, valid_o never rises; new start at 12
//    -> completes normally at cycle 12+33.
//  6 DONE with ready_i=0 for 3 cycles -> valid_o and result_o constant; ready_i=1 -> IDLE next.

Source files
------------

// File: rtl/div_unit_pkg.sv
//==============================================================================
// Module   : div_unit_pkg
// Brief    : Shared types and constants for the iterative divider.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package div_unit_pkg;

    localparam int c_div_width = 32;
    localparam int c_div_cnt_w = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage : div_unit_pkg

`default_nettype wire

// File: rtl/div_unit_if.sv
//==============================================================================
// Module   : div_unit_if
// Brief    : Request/result bundle between the EX stage and the divider.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 signed_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 flush_i;
    logic                 ready_i;
    logic                 stall_o;
    logic [2*WIDTH-1:0]   result_o;
    logic                 valid_o;

    modport master (
        output start_i, signed_i, a_i, b_i, flush_i, ready_i,
        input  stall_o, result_o, valid_o
    );

    modport slave (
        input  start_i, signed_i, a_i, b_i, flush_i, ready_i,
        output stall_o, result_o, valid_o
    );
endinterface : div_unit_if

`default_nettype wire

// File: rtl/div_unit.sv
//==============================================================================
// Module   : div_unit
// Brief    : Radix-2 restoring 32-bit DIV/DIVU, result {remainder, quotient}.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = c_div_width,
    parameter int CNT_W = c_div_cnt_w
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);

    div_state_e           r_state;
    div_state_e           w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_dvd;
    logic [WIDTH-1:0]     r_dvs;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_b_zero;
    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic                 w_qbit;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quo_nxt;
    logic [WIDTH-1:0]     w_neg_x_in;
    logic [WIDTH-1:0]     w_neg_y_in;
    logic [WIDTH-1:0]     w_neg_x;
    logic [WIDTH-1:0]     w_neg_y;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH-1:0]     w_fix_q;
    logic [WIDTH-1:0]     w_fix_r;

    assign w_b_zero = (bus.b_i == '0);
    assign w_accept = (r_state == DIV_IDLE) && bus.start_i && !bus.flush_i;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // 33-bit trial subtract: a clear borrow bit means shifted remainder >= divisor.
    assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_qbit};

    // One pair of negators serves operand magnitudes in IDLE and the final sign fix in BUSY.
    assign w_neg_x_in = (r_state == DIV_BUSY) ? w_quo_nxt : bus.a_i;
    assign w_neg_y_in = (r_state == DIV_BUSY) ? w_rem_nxt : bus.b_i;
    assign w_neg_x    = -w_neg_x_in;
    assign w_neg_y    = -w_neg_y_in;

    assign w_abs_a = (bus.signed_i && bus.a_i[WIDTH-1]) ? w_neg_x : bus.a_i;
    assign w_abs_b = (bus.signed_i && bus.b_i[WIDTH-1]) ? w_neg_y : bus.b_i;
    assign w_fix_q = r_neg_q ? w_neg_x : w_quo_nxt;
    assign w_fix_r = r_neg_r ? w_neg_y : w_rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        bus.stall_o = 1'b0;
        bus.valid_o = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (w_accept) begin
                    w_next      = w_b_zero ? DIV_DONE : DIV_BUSY;
                    bus.stall_o = !w_b_zero;
                end
            end
            DIV_BUSY: begin
                bus.stall_o = 1'b1;
                if (w_last) begin
                    w_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                bus.valid_o = 1'b1;
                if (bus.ready_i) begin
                    w_next = DIV_IDLE;
                end
            end
            default: w_next = DIV_IDLE;
        endcase
        if (bus.flush_i) begin
            w_next = DIV_IDLE;
        end
        if (rst) begin
            bus.stall_o = 1'b0;
            bus.valid_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (r_state == DIV_IDLE) begin
            if (w_accept) begin
                if (w_b_zero) begin
                    r_result <= {bus.a_i, {WIDTH{1'b1}}};
                end else begin
                    r_dvd   <= w_abs_a;
                    r_dvs   <= w_abs_b;
                    r_neg_q <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                    r_neg_r <= bus.signed_i & bus.a_i[WIDTH-1];
                    r_cnt   <= '0;
                    r_rem   <= '0;
                end
            end
        end else if (r_state == DIV_BUSY && !bus.flush_i) begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_quo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= {w_fix_r, w_fix_q};
            end
        end
    end

    assign bus.result_o = r_result;

endmodule : div_unit

`default_nettype wire
